// File: rtl/serial_pair_serializer.sv
// rtl/serial_pair_serializer.sv - parallel operand pair to aligned serial bit streams
// Bit order is selected at compile time by SERIAL_PAIR_MSB_FIRST_EN:
// defined gives most-significant bit first; undefined gives least-significant bit first.
module serial_pair_serializer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_a,
   output logic             out_b,
   output logic             out_first,
   output logic             out_last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          state;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic [CW-1:0]   count;

   logic            in_shift;
   logic            at_last;
   logic            advance;
   logic            accept;
   logic            head_a;
   logic            head_b;
   logic [WIDTH-1:0] next_a;
   logic [WIDTH-1:0] next_b;

`ifdef SERIAL_PAIR_MSB_FIRST_EN
   assign head_a = shift_a[WIDTH-1];
   assign head_b = shift_b[WIDTH-1];
   assign next_a = {shift_a[WIDTH-2:0], 1'b0};
   assign next_b = {shift_b[WIDTH-2:0], 1'b0};
`else
   assign head_a = shift_a[0];
   assign head_b = shift_b[0];
   assign next_a = {1'b0, shift_a[WIDTH-1:1]};
   assign next_b = {1'b0, shift_b[WIDTH-1:1]};
`endif

   assign in_shift = (state == SHIFT);
   assign at_last  = in_shift && (count == LAST_COUNT);
   assign advance  = in_shift && out_ready;

   // A new pair can enter when idle, or exactly as the last bit of the held word is consumed,
   // which lets back-to-back words stream without a bubble.
   assign in_ready = !in_shift || (at_last && out_ready);
   assign accept   = in_valid && in_ready;

   assign out_valid = in_shift;
   assign out_a     = in_shift && head_a;
   assign out_b     = in_shift && head_b;
   assign out_first = in_shift && (count == '0);
   assign out_last  = at_last;

   // State, bit counter and both shift registers; everything holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         count   <= '0;
         shift_a <= '0;
         shift_b <= '0;
      end else if (accept) begin
         state   <= SHIFT;
         count   <= '0;
         shift_a <= in_a;
         shift_b <= in_b;
      end else if (advance) begin
         if (at_last) begin
            state   <= IDLE;
            count   <= '0;
            shift_a <= '0;
            shift_b <= '0;
         end else begin
            count   <= count + 1'b1;
            shift_a <= next_a;
            shift_b <= next_b;
         end
      end
   end

endmodule

// File: tb/tb_serial_pair_serializer.sv
// tb/tb_serial_pair_serializer.sv - directed vector bench for serial_pair_serializer (WIDTH=4)
module tb_serial_pair_serializer;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic         out_a;
   logic         out_b;
   logic         out_first;
   logic         out_last;

   int passed;
   int total;

   serial_pair_serializer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_first (out_first),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Emission sequences: bit i of a seq field is the i-th serial bit emitted.
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lsb_a;
      logic [W-1:0] lsb_b;
      logic [W-1:0] msb_a;
      logic [W-1:0] msb_b;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [W-1:0] seq_a(input vec_t v);
`ifdef SERIAL_PAIR_MSB_FIRST_EN
      return v.msb_a;
`else
      return v.lsb_a;
`endif
   endfunction

   function automatic logic [W-1:0] seq_b(input vec_t v);
`ifdef SERIAL_PAIR_MSB_FIRST_EN
      return v.msb_b;
`else
      return v.lsb_b;
`endif
   endfunction

   // {valid, first, last, a, b} expected while bit i of vector v is presented
   function automatic logic [4:0] exp_out(input vec_t v, input int i);
      logic [W-1:0] sa;
      logic [W-1:0] sb;
      sa = seq_a(v);
      sb = seq_b(v);
      return {1'b1, (i == 0), (i == W - 1), sa[i], sb[i]};
   endfunction

   function automatic logic [4:0] obs();
      return {out_valid, out_first, out_last, out_a, out_b};
   endfunction

   initial begin
      logic [W-1:0] word_a;
      logic [W-1:0] word_b;
      logic [W-1:0] qa[$];
      logic [W-1:0] qb[$];
      logic [W-1:0] pend_a;
      logic [W-1:0] pend_b;
      int           sent;
      int           words;
      int           k;
      int           cyc;
      logic         marks_ok;
      logic         have_pend;

      passed = 0;
      total  = 0;
      vecs[0] = '{a: 4'b0110, b: 4'b0010, lsb_a: 4'b0110, lsb_b: 4'b0010, msb_a: 4'b0110, msb_b: 4'b0100};
      vecs[1] = '{a: 4'b1000, b: 4'b0001, lsb_a: 4'b1000, lsb_b: 4'b0001, msb_a: 4'b0001, msb_b: 4'b1000};
      vecs[2] = '{a: 4'b1101, b: 4'b1011, lsb_a: 4'b1101, lsb_b: 4'b1011, msb_a: 4'b1011, msb_b: 4'b1101};
      vecs[3] = '{a: 4'b1111, b: 4'b0000, lsb_a: 4'b1111, lsb_b: 4'b0000, msb_a: 4'b1111, msb_b: 4'b0000};
      vecs[4] = '{a: 4'b0101, b: 4'b1010, lsb_a: 4'b0101, lsb_b: 4'b1010, msb_a: 4'b1010, msb_b: 4'b0101};

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", {26'd0, obs(), in_ready}, {26'd0, 5'b00000, 1'b1});
      rst = 1'b1;

      // table-driven words, first accept right after reset release
      for (int v = 0; v < 5; v++) begin
         chk("idle_ready", {30'd0, out_valid, in_ready}, 32'b01);
         in_valid = 1'b1;
         in_a     = vecs[v].a;
         in_b     = vecs[v].b;
         for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            chk($sformatf("vec%0d_bit%0d", v, i), {27'd0, obs()}, {27'd0, exp_out(vecs[v], i)});
            chk($sformatf("vec%0d_rdy%0d", v, i), {31'd0, in_ready}, {31'd0, (i == W - 1)});
         end
         @(negedge clk);
         chk($sformatf("vec%0d_after", v), {31'd0, out_valid}, 32'd0);
      end

      // back-to-back words with in_valid held high
      in_valid = 1'b1;
      in_a     = 4'hF;
      in_b     = 4'h0;
      @(negedge clk);
      in_a = 4'h0;
      in_b = 4'hF;
      for (int i = 0; i < 2 * W; i++) begin
         if (i == W + 1) in_valid = 1'b0;
         chk($sformatf("b2b_bit%0d", i), {27'd0, obs()},
             {27'd0, 1'b1, (i % W == 0), (i % W == W - 1), (i < W), (i >= W)});
         chk($sformatf("b2b_rdy%0d", i), {31'd0, in_ready}, {31'd0, (i % W == W - 1)});
         @(negedge clk);
      end
      chk("b2b_after", {30'd0, out_valid, in_ready}, 32'b01);

      // stall mid-word for three cycles
      in_valid = 1'b1;
      in_a     = vecs[0].a;
      in_b     = vecs[0].b;
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_bit0", {27'd0, obs()}, {27'd0, exp_out(vecs[0], 0)});
      @(negedge clk);
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("stall_hold%0d", s), {27'd0, obs()}, {27'd0, exp_out(vecs[0], 1)});
         chk($sformatf("stall_rdy%0d", s), {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int i = 1; i < W; i++) begin
         chk($sformatf("stall_resume%0d", i), {27'd0, obs()}, {27'd0, exp_out(vecs[0], i)});
         @(negedge clk);
      end
      chk("stall_after", {31'd0, out_valid}, 32'd0);

      // asynchronous reset mid-word
      in_valid = 1'b1;
      in_a     = 4'hF;
      in_b     = 4'hF;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_pre", {27'd0, obs()}, {27'd0, 5'b10011});
      #2 rst = 1'b0;
      #1 chk("rst_async", {26'd0, obs(), in_ready}, {26'd0, 5'b00000, 1'b1});
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst_release%0d", i), {26'd0, obs(), in_ready}, {26'd0, 5'b00000, 1'b1});
      end

      // random round trip with random stalls and gaps
      sent      = 0;
      words     = 0;
      k         = 0;
      cyc       = 0;
      marks_ok  = 1'b1;
      have_pend = 1'b0;
      word_a    = '0;
      word_b    = '0;
      pend_a    = '0;
      pend_b    = '0;
      while (words < 24 && cyc < 2000) begin
         if (!have_pend && sent < 24 && $urandom_range(3) != 0) begin
            pend_a    = W'($urandom);
            pend_b    = W'($urandom);
            have_pend = 1'b1;
         end
         in_valid  = have_pend;
         in_a      = have_pend ? pend_a : W'($urandom);
         in_b      = have_pend ? pend_b : W'($urandom);
         out_ready = ($urandom_range(3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (out_first !== (k == 0) || out_last !== (k == W - 1)) marks_ok = 1'b0;
`ifdef SERIAL_PAIR_MSB_FIRST_EN
            word_a[W-1-k] = out_a;
            word_b[W-1-k] = out_b;
`else
            word_a[k] = out_a;
            word_b[k] = out_b;
`endif
            k++;
            if (k == W) begin
               k = 0;
               if (qa.size() == 0) chk("rand_unexpected_word", 32'd1, 32'd0);
               else begin
                  chk($sformatf("rand_word%0d", words), {24'd0, word_a, word_b},
                      {24'd0, qa.pop_front(), qb.pop_front()});
               end
               words++;
            end
         end
         if (in_valid && in_ready) begin
            qa.push_back(pend_a);
            qb.push_back(pend_b);
            have_pend = 1'b0;
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk("rand_word_count", words, 24);
      chk("rand_markers", {31'd0, marks_ok}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
